// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch history table.
package branch_predictor_pkg;

  localparam int unsigned PC_W = 32;

  // 2-bit saturating counter states; predict taken iff bit 1 is set.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_e;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic for one 2-bit saturating taken/not-taken counter.
module branch_predictor_sat_counter2
  import branch_predictor_pkg::*;
(
  input  cnt_e cnt,
  input  logic taken,
  output cnt_e cnt_next
);

  always_comb begin
    cnt_next = cnt;
    unique case (cnt)
      SNT: cnt_next = taken ? WNT : SNT;
      WNT: cnt_next = taken ? WT  : SNT;
      WT:  cnt_next = taken ? ST  : WNT;
      ST:  cnt_next = taken ? ST  : WT;
      default: cnt_next = cnt;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch history table: combinational fetch lookup, execute-stage
// training, and branch/mispredict statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned LINES = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bp_enable,
  input  logic [PC_W-1:0]  pc_guess,
  input  logic             is_br_guess,
  output logic             br_taken_guess,
  input  logic [PC_W-1:0]  pc_check,
  input  logic             is_br_check,
  input  logic             br_taken_check,
  input  logic             pred_taken_check,
  input  logic             stall,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int unsigned IDX   = $clog2(LINES);
  localparam int unsigned TAG_W = PC_W - IDX - 2;

  logic             valid_q [LINES];
  logic [TAG_W-1:0] tag_q   [LINES];
  cnt_e             cnt_q   [LINES];

  logic [IDX-1:0]   idx_g;
  logic [TAG_W-1:0] tag_g;
  logic [IDX-1:0]   idx_c;
  logic [TAG_W-1:0] tag_c;
  logic             hit_c;
  logic             upd_c;
  cnt_e             cnt_sat_c;
  cnt_e             cnt_new_c;
  logic             unused_pc_bits;

  assign idx_g = pc_guess[IDX+1:2];
  assign tag_g = pc_guess[PC_W-1:IDX+2];
  assign idx_c = pc_check[IDX+1:2];
  assign tag_c = pc_check[PC_W-1:IDX+2];

  // Instructions are word aligned, so the low PC bits never select an entry.
  assign unused_pc_bits = ^{pc_guess[1:0], pc_check[1:0]};

  // Fetch lookup reads the flops directly, so same-cycle updates are not visible.
  assign br_taken_guess = bp_enable & is_br_guess & valid_q[idx_g]
                        & (tag_q[idx_g] == tag_g) & cnt_q[idx_g][1];

  assign hit_c = valid_q[idx_c] & (tag_q[idx_c] == tag_c);
  assign upd_c = is_br_check & ~stall;

  branch_predictor_sat_counter2 u_sat (
    .cnt      (cnt_q[idx_c]),
    .taken    (br_taken_check),
    .cnt_next (cnt_sat_c)
  );

  // A fresh allocation starts in the weak state matching the first outcome.
  assign cnt_new_c = hit_c ? cnt_sat_c : (br_taken_check ? WT : WNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LINES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        cnt_q[i]   <= SNT;
      end
      br_count      <= '0;
      mispred_count <= '0;
    end else if (upd_c) begin
      valid_q[idx_c] <= 1'b1;
      tag_q[idx_c]   <= tag_c;
      cnt_q[idx_c]   <= cnt_new_c;
      br_count       <= br_count + CNT_W'(1);
      if (pred_taken_check != br_taken_check)
        mispred_count <= mispred_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scenario bench for branch_predictor: expectations queued as stimulus is
// driven, observations queued at the falling edge, both drained per scenario.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        bp_enable;
  logic [31:0] pc_guess;
  logic        is_br_guess;
  logic        br_taken_guess;
  logic [31:0] pc_check;
  logic        is_br_check;
  logic        br_taken_check;
  logic        pred_taken_check;
  logic        stall;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  typedef struct {
    string       name;
    logic [64:0] v;
  } exp_t;

  exp_t        exp_q[$];
  logic [64:0] obs_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  branch_predictor #(.LINES(32), .CNT_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .bp_enable        (bp_enable),
    .pc_guess         (pc_guess),
    .is_br_guess      (is_br_guess),
    .br_taken_guess   (br_taken_guess),
    .pc_check         (pc_check),
    .is_br_check      (is_br_check),
    .br_taken_check   (br_taken_check),
    .pred_taken_check (pred_taken_check),
    .stall            (stall),
    .br_count         (br_count),
    .mispred_count    (mispred_count)
  );

  function automatic exp_t mk(input string n, input logic g, input int br, input int mis);
    exp_t e;
    e.name = n;
    e.v    = {g, 32'(br), 32'(mis)};
    return e;
  endfunction

  // Observe at the falling edge, then step past the next rising edge.
  task automatic look(input logic [31:0] pc);
    pc_guess    = pc;
    is_br_guess = 1'b1;
    @(negedge clk);
    obs_q.push_back({br_taken_guess, br_count, mispred_count});
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic pred);
    is_br_check      = 1'b1;
    pc_check         = pc;
    br_taken_check   = taken;
    pred_taken_check = pred;
    @(posedge clk);
    #1;
    is_br_check = 1'b0;
  endtask

  task automatic test_reset;
    exp_t e;
    logic [64:0] o;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back(mk("reset_lookup", 1'b0, 0, 0));
    look(32'h1000_0000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.name, o, e.v); end
    end
  endtask

  task automatic test_train;
    exp_t e;
    logic [64:0] o;
    upd(32'h1000_0010, 1'b1, 1'b0);
    exp_q.push_back(mk("train_alloc_taken", 1'b1, 1, 1)); look(32'h1000_0010);
    exp_q.push_back(mk("non_branch_lookup", 1'b0, 1, 1));
    is_br_guess = 1'b0; pc_guess = 32'h1000_0010;
    @(negedge clk); obs_q.push_back({br_taken_guess, br_count, mispred_count});
    @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.name, o, e.v); end
    end
  endtask

  task automatic test_saturate;
    exp_t e;
    logic [64:0] o;
    repeat (3) upd(32'h1000_0010, 1'b1, 1'b1);
    exp_q.push_back(mk("sat_strong_taken", 1'b1, 4, 1)); look(32'h1000_0010);
    upd(32'h1000_0010, 1'b0, 1'b1);
    exp_q.push_back(mk("sat_down_to_wt", 1'b1, 5, 2)); look(32'h1000_0010);
    upd(32'h1000_0010, 1'b0, 1'b1);
    exp_q.push_back(mk("sat_down_to_wnt", 1'b0, 6, 3)); look(32'h1000_0010);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.name, o, e.v); end
    end
  endtask

  task automatic test_alias;
    exp_t e;
    logic [64:0] o;
    upd(32'h1000_0010, 1'b1, 1'b0);
    exp_q.push_back(mk("alias_other_tag", 1'b0, 7, 4)); look(32'h1000_0090);
    exp_q.push_back(mk("alias_owner_hit", 1'b1, 7, 4)); look(32'h1000_0010);
    upd(32'h1000_0090, 1'b0, 1'b0);
    exp_q.push_back(mk("alias_new_wnt", 1'b0, 8, 4));   look(32'h1000_0090);
    exp_q.push_back(mk("alias_evicted", 1'b0, 8, 4));   look(32'h1000_0010);
    upd(32'h1000_0090, 1'b1, 1'b0);
    exp_q.push_back(mk("alias_wnt_to_wt", 1'b1, 9, 5)); look(32'h1000_0090);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.name, o, e.v); end
    end
  endtask

  task automatic test_enable;
    exp_t e;
    logic [64:0] o;
    upd(32'h1000_0020, 1'b1, 1'b0);
    upd(32'h1000_0020, 1'b1, 1'b1);
    bp_enable = 1'b0;
    exp_q.push_back(mk("disabled_guess", 1'b0, 11, 6)); look(32'h1000_0020);
    upd(32'h1000_0020, 1'b0, 1'b0);
    bp_enable = 1'b1;
    exp_q.push_back(mk("reenabled_guess", 1'b1, 12, 6)); look(32'h1000_0020);
    upd(32'h1000_0020, 1'b0, 1'b1);
    exp_q.push_back(mk("trained_while_off", 1'b0, 13, 7)); look(32'h1000_0020);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.name, o, e.v); end
    end
  endtask

  task automatic test_same_cycle_and_stall;
    exp_t e;
    logic [64:0] o;
    upd(32'h1000_0030, 1'b0, 1'b0);
    exp_q.push_back(mk("same_cycle_old", 1'b0, 14, 7));
    is_br_check = 1'b1; pc_check = 32'h1000_0030;
    br_taken_check = 1'b1; pred_taken_check = 1'b0;
    look(32'h1000_0030);
    is_br_check = 1'b0;
    exp_q.push_back(mk("same_cycle_new", 1'b1, 15, 8)); look(32'h1000_0030);
    stall = 1'b1;
    upd(32'h1000_0030, 1'b0, 1'b1);
    upd(32'h1000_0070, 1'b1, 1'b0);
    stall = 1'b0;
    exp_q.push_back(mk("stall_hold", 1'b1, 15, 8));      look(32'h1000_0030);
    exp_q.push_back(mk("stall_no_alloc", 1'b0, 15, 8));  look(32'h1000_0070);
    pc_check = 32'h1000_0030; br_taken_check = 1'b0; pred_taken_check = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(mk("non_branch_check", 1'b1, 15, 8)); look(32'h1000_0030);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.name, o, e.v); end
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    logic [64:0] o;
    rst = 1'b1;
    upd(32'h1000_0040, 1'b1, 1'b0);
    rst = 1'b0;
    exp_q.push_back(mk("rst_clears_entry", 1'b0, 0, 0)); look(32'h1000_0030);
    exp_q.push_back(mk("rst_drops_update", 1'b0, 0, 0)); look(32'h1000_0040);
    upd(32'h1000_0040, 1'b1, 1'b1);
    exp_q.push_back(mk("post_rst_train", 1'b1, 1, 0));   look(32'h1000_0040);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.name, o, e.v); end
    end
  endtask

  initial begin
    rst = 1'b1; bp_enable = 1'b1; pc_guess = '0; is_br_guess = 1'b0;
    pc_check = '0; is_br_check = 1'b0; br_taken_check = 1'b0;
    pred_taken_check = 1'b0; stall = 1'b0;
    @(posedge clk);
    #1;
    test_reset;
    test_train;
    test_saturate;
    test_alias;
    test_enable;
    test_same_cycle_and_stall;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
